// File: rtl/serial_adder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder/subtractor. Both operands are latched on start and then
// processed one bit per clock, LSB first, through a single full-adder cell and
// a carry flop. The result, carry-out / no-borrow and signed overflow are
// published together when the operation completes, with a one-cycle done pulse.
//
// Parameters
//   WIDTH     operand/result width in bits (>= 1)
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset; aborts any operation in flight
//   start     request an operation (sampled only when idle or done)
//   sub       0 = a+b, 1 = a-b; latched with start
//   a, b      operands; latched with start
//   busy      high while bits are being processed
//   done      one-cycle pulse; sum/carry/overflow valid from this cycle
//   sum       result, held until the next completion
//   carry     add: carry-out; sub: 1 = no borrow (a >= b unsigned)
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  // Bit counter is at least one bit wide so WIDTH=1 still has a legal vector.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;     // holds ~b for subtraction
  logic             c_reg;     // running carry; preset to 1 for subtraction
  logic [CW-1:0]    cnt_reg;

  // Single full-adder cell working on the current LSBs.
  logic s_bit;
  logic c_next;

  assign s_bit  = a_reg[0] ^ b_reg[0] ^ c_reg;
  assign c_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & c_reg) | (b_reg[0] & c_reg);

  // res_shift is the partial result after the current bit has been inserted at
  // the MSB end. Only WIDTH-1 bits need to be stored between cycles: on the last
  // bit the final value is taken straight from res_shift into sum.
  logic [WIDTH-1:0] res_shift;

  generate
    if (WIDTH == 1) begin : g_w1
      assign res_shift = s_bit;
    end else begin : g_wn
      logic [WIDTH-2:0] res_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          res_reg <= '0;
        end else if (state_reg == RUN) begin
          res_reg <= res_shift[WIDTH-1:1];
        end
      end

      assign res_shift = {s_bit, res_reg};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= 1'b0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          // done is a single-cycle pulse; a start seen in DONE chains the next
          // operation with no idle gap.
          done <= 1'b0;
          if (start) begin
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            c_reg     <= sub;      // the +1 of two's complement negation
            cnt_reg   <= '0;
            state_reg <= RUN;
            busy      <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end

        RUN: begin
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          c_reg   <= c_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_BIT) begin
            // c_reg is the carry into the MSB at this point, c_next the carry out.
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            sum       <= res_shift;
            carry     <= c_next;
            overflow  <= c_reg ^ c_next;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
`timescale 1ns/1ps
// Testbench for serial_adder: one WIDTH=8 instance and one WIDTH=1 instance.
// Stimulus pushes expected results into a per-instance queue; a monitor on the
// falling edge pops and compares whenever done is seen, and otherwise checks
// that the published result is being held.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start_v [2];
  logic       sub_v   [2];
  logic [7:0] a_v     [2];
  logic [7:0] b_v     [2];

  logic       busy0, done0, carry0, ovf0;
  logic [7:0] sum0;
  logic       busy1, done1, carry1, ovf1;
  logic [0:0] sum1;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]),
    .a(a_v[0]), .b(b_v[0]),
    .busy(busy0), .done(done0), .sum(sum0), .carry(carry0), .overflow(ovf0)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]),
    .a(a_v[1][0:0]), .b(b_v[1][0:0]),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1), .overflow(ovf1)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t held [2];
  int   checks = 0;
  int   fails  = 0;
  bit   mon_en = 1'b0;

  // Directed cases with hand-derived results.
  logic [7:0] dir_a   [4] = '{8'h5A, 8'hFF, 8'h10, 8'h80};
  logic [7:0] dir_b   [4] = '{8'h3C, 8'h01, 8'h20, 8'h01};
  logic       dir_s   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] dir_sum [4] = '{8'h96, 8'h00, 8'hF0, 8'h7F};
  logic       dir_c   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic       dir_v   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  // Half-adder truth table for the 1-bit instance: (a,b) -> (sum,carry).
  logic       ha_a [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic       ha_b [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic       ha_s [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic       ha_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  function automatic int wof(input int d);
    return (d == 0) ? 8 : 1;
  endfunction

  function automatic logic get_busy(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction
  function automatic logic get_done(input int d);
    return (d == 0) ? done0 : done1;
  endfunction
  function automatic logic [7:0] get_sum(input int d);
    return (d == 0) ? sum0 : {7'b0, sum1};
  endfunction
  function automatic logic get_carry(input int d);
    return (d == 0) ? carry0 : carry1;
  endfunction
  function automatic logic get_ovf(input int d);
    return (d == 0) ? ovf0 : ovf1;
  endfunction

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic s, input int c);
    exp_t e;
    int m, av, bv, r, sa, sb, t;
    m  = 1 << w;
    av = int'(a) & (m - 1);
    bv = int'(b) & (m - 1);
    r  = s ? (av - bv) : (av + bv);
    sa = (av >= m / 2) ? av - m : av;
    sb = (bv >= m / 2) ? bv - m : bv;
    t  = s ? (sa - sb) : (sa + sb);
    e.a     = a;
    e.b     = b;
    e.s     = s;
    e.sum   = 8'((r + m) % m);
    e.carry = s ? (av >= bv) : (av + bv >= m);
    e.ovf   = (t < -(m / 2)) || (t >= m / 2);
    e.cyc   = c;
    return e;
  endfunction

  task automatic chk(input string name, input int d, input int act, input int expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (cycle %0d)", name, d, act, expv, cyc);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  task automatic mon(input int d);
    exp_t e;
    int   qs;
    chk("busy_and_done", d, int'(get_busy(d) & get_done(d)), 0);
    qs = (d == 0) ? q0.size() : q1.size();
    if (get_done(d)) begin
      if (qs == 0) begin
        chk("spurious_done", d, int'(get_done(d)), 0);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        $display("dut%0d %s a=%02h b=%02h -> sum=%02h carry=%0b ovf=%0b (expect %02h %0b %0b)",
                 d, e.s ? "sub" : "add", e.a, e.b, get_sum(d), get_carry(d), get_ovf(d),
                 e.sum, e.carry, e.ovf);
        chk("sum",      d, int'(get_sum(d)),   int'(e.sum));
        chk("carry",    d, int'(get_carry(d)), int'(e.carry));
        chk("overflow", d, int'(get_ovf(d)),   int'(e.ovf));
        chk("latency",  d, cyc - e.cyc,        wof(d));
        held[d] = e;
      end
    end else begin
      chk("result_hold", d, int'({get_sum(d), get_carry(d), get_ovf(d)}),
          int'({held[d].sum, held[d].carry, held[d].ovf}));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) mon(d);
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Present an operation and let the next edge accept it. Caller guarantees
  // the DUT is in IDLE or DONE at that edge. hold keeps start asserted.
  task automatic launch(input int d, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input bit hold);
    a_v[d] = a;
    b_v[d] = b;
    sub_v[d] = s;
    start_v[d] = 1'b1;
    @(posedge clk);
    #1;
    push(d, model(wof(d), a, b, s, cyc));
    if (!hold) start_v[d] = 1'b0;
  endtask

  // Scramble the inputs while the DUT is running; all of it must be ignored.
  task automatic noise(input int d, input int n, input bit keep_start);
    for (int i = 0; i < n; i++) begin
      a_v[d] = 8'($urandom);
      b_v[d] = 8'($urandom);
      sub_v[d] = 1'($urandom);
      start_v[d] = keep_start ? 1'b1 : 1'($urandom);
      @(posedge clk);
      #1;
    end
    start_v[d] = keep_start;
  endtask

  task automatic wait_done(input int d);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (get_done(d)) return;
    end
    chk("done_timeout", d, int'(get_done(d)), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold reset for n edges with start asserted; everything must stay cleared.
  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b1;
      a_v[d] = 8'($urandom);
      b_v[d] = 8'($urandom);
    end
    repeat (n) begin
      @(posedge clk);
      #1;
      q0.delete();
      q1.delete();
      held[0] = '0;
      held[1] = '0;
      mon_en = 1'b1;
      for (int d = 0; d < 2; d++) begin
        chk("rst_busy", d, int'(get_busy(d)), 0);
        chk("rst_done", d, int'(get_done(d)), 0);
        chk("rst_outputs", d, int'({get_sum(d), get_carry(d), get_ovf(d)}), 0);
      end
    end
    rst = 1'b0;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit hold;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0;
      sub_v[d] = 1'b0;
      a_v[d] = '0;
      b_v[d] = '0;
    end

    do_reset(2);
    idle(2);

    // Directed add/sub cases against hand-derived values.
    for (int i = 0; i < 4; i++) begin
      launch(0, dir_a[i], dir_b[i], dir_s[i], 1'b0);
      wait_done(0);
      chk("dir_sum",   0, int'(sum0),   int'(dir_sum[i]));
      chk("dir_carry", 0, int'(carry0), int'(dir_c[i]));
      chk("dir_ovf",   0, int'(ovf0),   int'(dir_v[i]));
      idle(1);
    end

    // Inputs and start toggled mid-RUN.
    launch(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    noise(0, 6, 1'b0);
    wait_done(0);
    idle(1);

    // start held through DONE: next operation begins with no idle cycle.
    launch(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    noise(0, 5, 1'b1);
    wait_done(0);
    launch(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    chk("b2b_busy", 0, int'(busy0), 1);
    wait_done(0);
    idle(1);

    // Reset in the middle of RUN: no done, cleared result, then a clean op.
    launch(0, 8'hC3, 8'h5D, 1'b0, 1'b0);
    idle(3);
    chk("busy_before_abort", 0, int'(busy0), 1);
    do_reset(1);
    idle(12);
    launch(0, 8'h7F, 8'h01, 1'b0, 1'b0);
    wait_done(0);
    idle(1);

    // Randomised operations with random gaps, noise and chaining.
    for (int i = 0; i < 30; i++) begin
      hold = (i != 29) && ($urandom_range(0, 2) == 0);
      launch(0, 8'($urandom), 8'($urandom), 1'($urandom), hold);
      if ($urandom_range(0, 1) == 1) noise(0, $urandom_range(1, 6), hold);
      wait_done(0);
      if (!hold) idle($urandom_range(0, 2));
    end
    idle(2);

    // One-bit instance: half-adder truth table, then random add/sub.
    for (int i = 0; i < 4; i++) begin
      launch(1, {7'b0, ha_a[i]}, {7'b0, ha_b[i]}, 1'b0, 1'b0);
      wait_done(1);
      chk("ha_sum",   1, int'(sum1),   int'(ha_s[i]));
      chk("ha_carry", 1, int'(carry1), int'(ha_c[i]));
      idle(1);
    end
    for (int i = 0; i < 16; i++) begin
      launch(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      wait_done(1);
      idle($urandom_range(0, 1));
    end

    idle(3);
    chk("queue_drained", 0, q0.size(), 0);
    chk("queue_drained", 1, q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
